wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Two-master Wishbone B4 classic arbiter in front of wb_intercon's single io master port.
//  Port m0 = core data path (wishbone_controller); port m1 = boot-loader/debug master that fills imem/dmem.
//  Grants one master at a time, holds the grant for the whole cyc, round-robins on contention.
//  Output side drives wb_io_* exactly as wishbone_controller does today.
// PARAMETERS
//  AW              32   address width, all ports
//  DW              32   data width, all ports; sel width = DW/8
//  TIMEOUT_CYCLES  255  stb-without-ack cycles before forced error (WB_ARB_TIMEOUT_EN only); 8-bit counter
// PORTS
//  clk                 in   1      system clock; all state on rising edge
//  reset_n             in   1      synchronous, active-low reset
//  m0_adr_i/m1_adr_i   in   AW     master address
//  m0_dat_i/m1_dat_i   in   DW     master write data
//  m0_sel_i/m1_sel_i   in   DW/8   byte enables
//  m0_we_i/m1_we_i     in   1      write enable
//  m0_cyc_i/m1_cyc_i   in   1      cycle request; also the bus request
//  m0_stb_i/m1_stb_i   in   1      strobe
//  m0_dat_o/m1_dat_o   out  DW     read data, broadcast of wb_io_dat_i
//  m0_ack_o/m1_ack_o   out  1      ack, granted master only
//  m0_err_o/m1_err_o   out  1      error, granted master only
//  wb_io_adr_o         out  AW     to interconnect
//  wb_io_dat_o         out  DW     to interconnect
//  wb_io_sel_o         out  DW/8   to interconnect
//  wb_io_we_o          out  1      to interconnect
//  wb_io_cyc_o         out  1      to interconnect
//  wb_io_stb_o         out  1      to interconnect
//  wb_io_dat_i         in   DW     from interconnect
//  wb_io_ack_i         in   1      from interconnect
//  wb_io_err_i         in   1      from interconnect
//  gnt_o               out  2      one-hot current grant {m1,m0}; 2'b00 in IDLE
//  timeout_o           out  1      1-cycle pulse when a timeout fires
// BEHAVIOUR
//  - FSM: IDLE, GNT0, GNT1. Reset (reset_n=0 at clk edge): IDLE, last_gnt=1, counter=0.
//  - Reset values: wb_io_* outputs all 0, m*_ack_o/m*_err_o 0, gnt_o 2'b00, timeout_o 0.
//  - IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> master != last_gnt (m0 wins first after reset).
//  - Grant latency 1 cycle: cyc sampled in IDLE, bus driven from next cycle.
//  - GNTx: wb_io_* = mx_* combinationally; mx_ack_o = wb_io_ack_i, mx_err_o = wb_io_err_i; other master ack/err = 0.
//  - GNTx -> IDLE when mx_cyc_i=0 (sampled); last_gnt<=x. Min 1 IDLE cycle between grants.
//  - IDLE: wb_io_cyc_o/stb_o/we_o=0, adr/dat/sel=0; no ack/err to any master; stray wb_io_ack_i ignored.
//  - New cyc from the other master while GNTx: waits, not dropped; cyc stays high until served.
//  - Multi-transfer cycles (cyc held, stb toggling) stay in GNTx; no preemption ever.
//  - reset_n=0 mid-cycle: IDLE next edge, bus released, no ack/err emitted.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined: 8-bit counter, +1 per GNTx cycle with wb_io_stb_o=1 and ack=err=0.
//    Cleared on ack, err or IDLE. Counter == TIMEOUT_CYCLES: mx_err_o=1 for 1 cycle, timeout_o=1.
//    Same cycle: wb_io_cyc_o/stb_o forced 0; next state IDLE, last_gnt<=x.
//  - Not defined: no counter; err is passthrough only; timeout_o tied 0; TIMEOUT_CYCLES unused.
// TESTING
//  - m0 read 0x0000_0010, slave acks after 2 cycles with 0xDEADBEEF -> gnt_o=01 one cycle after cyc.
//    m0_ack_o=1 with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
//  - m0,m1 raise cyc same cycle after reset -> m0 first; m1 granted after m0 drops cyc plus 1 IDLE cycle.
//    Repeat: m1 wins next contention.
//  - m1 write 0x0000_1000 data 0x12345678 sel 4'hF -> wb_io_* match exactly.
//    m0 request mid-transfer stalls, then gets grant.
//  - reset_n=0 while GNT1 with stb high -> next cycle gnt_o=00, wb_io_cyc_o=0, no ack to m1.
//  - WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> m0_err_o and timeout_o pulse.
//    Pulse on 4th stalled cycle; bus released; without macro bus stays held indefinitely.
//  - Slave returns wb_io_err_i=1 on m1 access -> m1_err_o=1 same cycle, m0_err_o=0.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master Wishbone B4 classic arbiter, round-robin, grant held per cyc
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   wb_io_adr_o,
    output logic [DW-1:0]   wb_io_dat_o,
    output logic [DW/8-1:0] wb_io_sel_o,
    output logic            wb_io_we_o,
    output logic            wb_io_cyc_o,
    output logic            wb_io_stb_o,
    input  logic [DW-1:0]   wb_io_dat_i,
    input  logic            wb_io_ack_i,
    input  logic            wb_io_err_i,

    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   gnt_stb;
    logic   timeout_fire;

    always_comb begin
        gnt_stb = 1'b0;
        case (state_q)
            GNT0:    gnt_stb = m0_stb_i;
            GNT1:    gnt_stb = m1_stb_i;
            default: gnt_stb = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       stalled;

    // The watchdog fires on the TIMEOUT_CYCLES-th consecutive stalled strobe cycle.
    always_comb begin
        stalled      = (state_q != IDLE) && gnt_stb && !wb_io_ack_i && !wb_io_err_i;
        timeout_fire = stalled && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d    = (stalled && !timeout_fire) ? tmo_cnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [7:0] unused_tmo_param;

    assign unused_tmo_param = 8'(TIMEOUT_CYCLES);
    assign timeout_fire     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || timeout_fire) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || timeout_fire) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Bus mux: the granted master drives the interconnect; IDLE releases everything to zero.
    always_comb begin
        wb_io_adr_o = '0;
        wb_io_dat_o = '0;
        wb_io_sel_o = '0;
        wb_io_we_o  = 1'b0;
        wb_io_cyc_o = 1'b0;
        wb_io_stb_o = 1'b0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        gnt_o       = 2'b00;
        case (state_q)
            GNT0: begin
                wb_io_adr_o = m0_adr_i;
                wb_io_dat_o = m0_dat_i;
                wb_io_sel_o = m0_sel_i;
                wb_io_we_o  = m0_we_i;
                wb_io_cyc_o = m0_cyc_i && !timeout_fire;
                wb_io_stb_o = m0_stb_i && !timeout_fire;
                m0_ack_o    = wb_io_ack_i;
                m0_err_o    = wb_io_err_i || timeout_fire;
                gnt_o       = 2'b01;
            end
            GNT1: begin
                wb_io_adr_o = m1_adr_i;
                wb_io_dat_o = m1_dat_i;
                wb_io_sel_o = m1_sel_i;
                wb_io_we_o  = m1_we_i;
                wb_io_cyc_o = m1_cyc_i && !timeout_fire;
                wb_io_stb_o = m1_stb_i && !timeout_fire;
                m1_ack_o    = wb_io_ack_i;
                m1_err_o    = wb_io_err_i || timeout_fire;
                gnt_o       = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_dat_o  = wb_io_dat_i;
    assign m1_dat_o  = wb_io_dat_i;
    assign timeout_o = timeout_fire;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb/tb_wb_master_arbiter.sv - directed self-checking bench for wb_master_arbiter
module tb_wb_master_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, wb_io_sel_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] wb_io_adr_o, wb_io_dat_o, wb_io_dat_i;
    logic        wb_io_we_o, wb_io_cyc_o, wb_io_stb_o, wb_io_ack_i, wb_io_err_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int n_assert = 0;
    int n_fail   = 0;
    int n_tmo    = 0;

    wb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .wb_io_adr_o(wb_io_adr_o), .wb_io_dat_o(wb_io_dat_o), .wb_io_sel_o(wb_io_sel_o),
        .wb_io_we_o(wb_io_we_o), .wb_io_cyc_o(wb_io_cyc_o), .wb_io_stb_o(wb_io_stb_o),
        .wb_io_dat_i(wb_io_dat_i), .wb_io_ack_i(wb_io_ack_i), .wb_io_err_i(wb_io_err_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        wb_io_dat_i = '0; wb_io_ack_i = 0; wb_io_err_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_bus", {wb_io_cyc_o, wb_io_stb_o, wb_io_we_o, wb_io_adr_o, wb_io_dat_o, wb_io_sel_o}, '0);
        check("rst_ackerr", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o}, 5'b0);

        // m0 read, slave acks two cycles into the grant
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        #1;
        check("rd_latency_gnt", gnt_o, 2'b00);
        tick();
        check("rd_gnt", gnt_o, 2'b01);
        check("rd_bus", {wb_io_cyc_o, wb_io_stb_o, wb_io_we_o, wb_io_adr_o}, {3'b110, 32'h0000_0010});
        tick();
        tick();
        wb_io_ack_i = 1; wb_io_dat_i = 32'hDEAD_BEEF;
        #1;
        check("rd_ack", {m0_ack_o, m0_dat_o}, {1'b1, 32'hDEAD_BEEF});
        check("rd_m1_ack", m1_ack_o, 1'b0);
        tick();
        wb_io_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        check("rd_release", {gnt_o, wb_io_cyc_o}, 3'b000);

        // Stray ack while IDLE reaches nobody
        wb_io_ack_i = 1; wb_io_err_i = 1;
        #1;
        check("idle_stray", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
        wb_io_ack_i = 0; wb_io_err_i = 0;

        // Contention right after reset: m0 first, then m1 after one IDLE cycle
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        check("cont1_gnt", gnt_o, 2'b01);
        wb_io_ack_i = 1;
        #1;
        check("cont1_ack", {m1_ack_o, m0_ack_o}, 2'b01);
        wb_io_ack_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        check("cont1_idle", gnt_o, 2'b00);
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        check("cont2_m1_wins", gnt_o, 2'b10);

        // m1 write with m0 waiting
        m1_adr_i = 32'h0000_1000; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'hF; m1_we_i = 1;
        #1;
        check("wr_bus", {wb_io_cyc_o, wb_io_stb_o, wb_io_we_o, wb_io_adr_o, wb_io_dat_o, wb_io_sel_o},
              {3'b111, 32'h0000_1000, 32'h1234_5678, 4'hF});
        tick();
        tick();
        check("wr_no_preempt", gnt_o, 2'b10);
        wb_io_ack_i = 1;
        #1;
        check("wr_ack", {m1_ack_o, m0_ack_o}, 2'b10);
        tick();
        wb_io_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        tick();
        check("wr_idle", gnt_o, 2'b00);
        tick();
        check("wr_m0_served", {gnt_o, wb_io_adr_o}, {2'b01, 32'h0});
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();

        // Slave error on m1 access
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        check("err_gnt", gnt_o, 2'b10);
        wb_io_err_i = 1;
        #1;
        check("err_route", {m1_err_o, m0_err_o}, 2'b10);
        wb_io_err_i = 0;

        // Reset while GNT1 with stb high
        tick();
        reset_n = 0;
        tick();
        wb_io_ack_i = 1;
        #1;
        check("midrst_bus", {gnt_o, wb_io_cyc_o, wb_io_stb_o}, 4'b0);
        check("midrst_ack", {m1_ack_o, m1_err_o}, 2'b00);
        reset_n = 1;
        clear_inputs();
        tick();

        // Slave never acks
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            n_tmo += int'(timeout_o);
            tick();
        end
        check("tmo_early", n_tmo, 0);
        check("tmo_fire", {timeout_o, m0_err_o, wb_io_cyc_o, wb_io_stb_o}, 4'b1100);
        tick();
        check("tmo_release", {gnt_o, timeout_o, m0_err_o}, 4'b0);
`else
        for (int i = 0; i < 300; i++) begin
            n_tmo += int'(timeout_o) + int'(m0_err_o);
            tick();
        end
        check("hold_no_tmo", n_tmo, 0);
        check("hold_bus", {gnt_o, wb_io_cyc_o, wb_io_stb_o}, 4'b0111);
`endif
        clear_inputs();
        tick();
        tick();
        check("final_idle", gnt_o, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
